// File: rtl/mem_access_unit_if.sv
// Data-bus bundle between the MEM-stage responder (master) and the memory/peripheral side (slave).
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage responder: runs loads/stores over a req/ack bus, stalls upstream while busy, drives MEM/WB.
// Optional misaligned-access trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_RegWrite,
  input  logic                     in_MemRead,
  input  logic                     in_MemWrite,
  input  logic [1:0]               in_MemtoReg,
  input  logic [31:0]              in_ALUOut,
  input  logic [4:0]               in_RegWriteAddr,
  input  logic [31:0]              in_RFReadData2,
  input  logic [31:0]              in_PC,
  output logic                     mem_stall,
  mem_access_unit_if.master        bus,
  output logic                     out_RegWrite,
  output logic [1:0]               out_MemtoReg,
  output logic [31:0]              out_ALUOut,
  output logic [4:0]               out_RegWriteAddr,
  output logic [31:0]              out_PC,
  output logic [31:0]              out_MemReadData,
  output logic                     out_BusErr,
  output logic                     out_AlignFault
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] tmo_cnt;
  logic        mem_op;
  logic        misaligned;
  logic        start;
  logic        at_limit;

  always_comb begin
    mem_op = in_MemRead | in_MemWrite;
`ifdef MEM_ALIGN_CHECK_EN
    misaligned = mem_op && (in_ALUOut[1:0] != 2'b00);
`else
    misaligned = 1'b0;
`endif
    start    = mem_op && !misaligned;
    at_limit = (tmo_cnt == TMO_LAST);
    // The last BUSY cycle (ack or timeout) releases upstream so EX/MEM advances with the MEM/WB load.
    if (state == IDLE) mem_stall = start;
    else               mem_stall = !bus.bus_ack && !at_limit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      tmo_cnt          <= '0;
      bus.bus_req      <= 1'b0;
      bus.bus_we       <= 1'b0;
      bus.bus_addr     <= '0;
      bus.bus_wdata    <= '0;
      out_RegWrite     <= 1'b0;
      out_MemtoReg     <= '0;
      out_ALUOut       <= '0;
      out_RegWriteAddr <= '0;
      out_PC           <= '0;
      out_MemReadData  <= '0;
      out_BusErr       <= 1'b0;
      out_AlignFault   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state          <= BUSY;
            tmo_cnt        <= '0;
            bus.bus_req    <= 1'b1;
            bus.bus_we     <= in_MemWrite;
            bus.bus_addr   <= {in_ALUOut[31:2], 2'b00};
            bus.bus_wdata  <= in_RFReadData2;
            out_RegWrite   <= 1'b0;
            out_BusErr     <= 1'b0;
            out_AlignFault <= 1'b0;
          end else begin
            out_RegWrite     <= in_RegWrite && !misaligned;
            out_MemtoReg     <= in_MemtoReg;
            out_ALUOut       <= in_ALUOut;
            out_RegWriteAddr <= in_RegWriteAddr;
            out_PC           <= in_PC;
            out_MemReadData  <= '0;
            out_BusErr       <= 1'b0;
            out_AlignFault   <= misaligned;
          end
        end

        BUSY: begin
          // EX/MEM was held throughout, so in_* still describe the access being finished.
          if (bus.bus_ack) begin
            state            <= IDLE;
            bus.bus_req      <= 1'b0;
            out_RegWrite     <= in_RegWrite;
            out_MemtoReg     <= in_MemtoReg;
            out_ALUOut       <= in_ALUOut;
            out_RegWriteAddr <= in_RegWriteAddr;
            out_PC           <= in_PC;
            out_MemReadData  <= bus.bus_we ? '0 : bus.bus_rdata;
            out_BusErr       <= 1'b0;
            out_AlignFault   <= 1'b0;
          end else if (at_limit) begin
            state            <= IDLE;
            bus.bus_req      <= 1'b0;
            out_RegWrite     <= 1'b0;
            out_MemtoReg     <= in_MemtoReg;
            out_ALUOut       <= in_ALUOut;
            out_RegWriteAddr <= in_RegWriteAddr;
            out_PC           <= in_PC;
            out_MemReadData  <= '0;
            out_BusErr       <= 1'b1;
            out_AlignFault   <= 1'b0;
          end else begin
            tmo_cnt        <= tmo_cnt + 16'd1;
            out_RegWrite   <= 1'b0;
            out_BusErr     <= 1'b0;
            out_AlignFault <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a transaction-level reference checked every cycle plus literal checks.
module tb_mem_access_unit;

  localparam int TO = 4;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_RegWrite, in_MemRead, in_MemWrite;
  logic [1:0]  in_MemtoReg;
  logic [31:0] in_ALUOut, in_RFReadData2, in_PC;
  logic [4:0]  in_RegWriteAddr;
  logic        mem_stall;
  logic        out_RegWrite, out_BusErr, out_AlignFault;
  logic [1:0]  out_MemtoReg;
  logic [31:0] out_ALUOut, out_PC, out_MemReadData;
  logic [4:0]  out_RegWriteAddr;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .in_RegWrite(in_RegWrite), .in_MemRead(in_MemRead), .in_MemWrite(in_MemWrite),
    .in_MemtoReg(in_MemtoReg), .in_ALUOut(in_ALUOut), .in_RegWriteAddr(in_RegWriteAddr),
    .in_RFReadData2(in_RFReadData2), .in_PC(in_PC),
    .mem_stall(mem_stall), .bus(bus),
    .out_RegWrite(out_RegWrite), .out_MemtoReg(out_MemtoReg), .out_ALUOut(out_ALUOut),
    .out_RegWriteAddr(out_RegWriteAddr), .out_PC(out_PC), .out_MemReadData(out_MemReadData),
    .out_BusErr(out_BusErr), .out_AlignFault(out_AlignFault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an access in flight, how many bus cycles it has used, and the MEM/WB result it will produce.
  bit          m_busy, m_req, m_we, m_full, m_mrd_valid;
  int          m_elapsed;
  logic [31:0] m_addr, m_wdata;
  logic        e_rw, e_be, e_af;
  logic [1:0]  e_mtr;
  logic [31:0] e_alu, e_pc, e_mrd;
  logic [4:0]  e_rwa;

  function automatic bit is_mem_op();
    return in_MemRead || in_MemWrite;
  endfunction

  function automatic bit is_misal();
    return ALIGN_CHK && is_mem_op() && (in_ALUOut % 4 != 0);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 0; m_req <= 0; m_elapsed <= 0; m_full <= 1; m_mrd_valid <= 1;
      e_rw <= 0; e_be <= 0; e_af <= 0; e_mtr <= 0; e_alu <= 0; e_pc <= 0; e_mrd <= 0; e_rwa <= 0;
    end else if (!m_busy && is_mem_op() && !is_misal()) begin
      m_busy <= 1; m_elapsed <= 0; m_req <= 1; m_we <= in_MemWrite;
      m_addr <= in_ALUOut - (in_ALUOut % 4); m_wdata <= in_RFReadData2;
      e_rw <= 0; e_be <= 0; e_af <= 0; m_full <= 0; m_mrd_valid <= 0;
    end else if (!m_busy || bus.bus_ack || m_elapsed == TO - 1) begin
      // Access finishes (or none was needed): MEM/WB takes the EX/MEM fields.
      e_mtr <= in_MemtoReg; e_alu <= in_ALUOut; e_rwa <= in_RegWriteAddr; e_pc <= in_PC;
      m_full <= 1;
      if (!m_busy) begin
        e_rw <= in_RegWrite && !is_misal(); e_af <= is_misal(); e_be <= 0; e_mrd <= 0; m_mrd_valid <= 1;
      end else if (bus.bus_ack) begin
        e_rw <= in_RegWrite; e_af <= 0; e_be <= 0; m_mrd_valid <= 1;
        e_mrd <= (in_MemRead && !in_MemWrite) ? bus.bus_rdata : 32'd0;
      end else begin
        e_rw <= 0; e_af <= 0; e_be <= 1; m_mrd_valid <= 0;
      end
      m_busy <= 0; m_req <= 0;
    end else begin
      m_elapsed <= m_elapsed + 1;
      e_rw <= 0; e_be <= 0; e_af <= 0; m_full <= 0; m_mrd_valid <= 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_stall", mem_stall,
            m_busy ? (!bus.bus_ack && m_elapsed != TO - 1) : (is_mem_op() && !is_misal()));
      check("model_req", bus.bus_req, m_req);
      if (m_req) begin
        check("model_we", bus.bus_we, m_we);
        check("model_addr", bus.bus_addr, m_addr);
        check("model_wdata", bus.bus_wdata, m_wdata);
      end
      check("model_rw", out_RegWrite, e_rw);
      check("model_buserr", out_BusErr, e_be);
      check("model_alignfault", out_AlignFault, e_af);
      if (m_full) begin
        check("model_memtoreg", out_MemtoReg, e_mtr);
        check("model_aluout", out_ALUOut, e_alu);
        check("model_rwaddr", out_RegWriteAddr, e_rwa);
        check("model_pc", out_PC, e_pc);
      end
      if (m_mrd_valid) check("model_mrd", out_MemReadData, e_mrd);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic rw, input logic mr, input logic mw, input logic [1:0] mtr,
                        input logic [31:0] alu, input logic [4:0] rwa, input logic [31:0] d2,
                        input logic [31:0] pc);
    in_RegWrite = rw; in_MemRead = mr; in_MemWrite = mw; in_MemtoReg = mtr;
    in_ALUOut = alu; in_RegWriteAddr = rwa; in_RFReadData2 = d2; in_PC = pc;
  endtask

  task automatic clear_op();
    set_op(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 5'd0, 32'd0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_req;
    rst = 1'b1;
    clear_op();
    bus.bus_ack = 1'b0;
    bus.bus_rdata = 32'd0;
    cyc(); cyc();
    @(negedge clk);
    check("reset_req", bus.bus_req, 0);
    check("reset_rw", out_RegWrite, 0);
    check("reset_alu", out_ALUOut, 0);
    check("reset_pc", out_PC, 0);
    check("reset_mrd", out_MemReadData, 0);
    check("reset_err", {out_BusErr, out_AlignFault}, 0);
    chk_en = 1'b1;

    // Plain ALU op
    cyc(); rst = 1'b0;
    set_op(1, 0, 0, 2'd0, 32'h10, 5'd5, 32'h0, 32'h8);
    @(negedge clk); check("alu_stall", mem_stall, 0);
    cyc(); clear_op();
    @(negedge clk);
    check("alu_rw", out_RegWrite, 1);
    check("alu_aluout", out_ALUOut, 32'h10);
    check("alu_rwaddr", out_RegWriteAddr, 5);

    // Load at 0x100, ack in the third BUSY cycle
    cyc(); set_op(1, 1, 0, 2'd1, 32'h100, 5'd7, 32'h0, 32'h40);
    @(negedge clk); check("ld_stall_c0", mem_stall, 1);
    cyc(); @(negedge clk);
    check("ld_req", bus.bus_req, 1);
    check("ld_addr", bus.bus_addr, 32'h100);
    check("ld_we", bus.bus_we, 0);
    check("ld_bubble_rw", out_RegWrite, 0);
    cyc(); @(negedge clk); check("ld_stall_c2", mem_stall, 1);
    cyc(); bus.bus_ack = 1'b1; bus.bus_rdata = 32'hDEADBEEF;
    @(negedge clk); check("ld_stall_ack", mem_stall, 0);
    cyc(); bus.bus_ack = 1'b0; clear_op();
    @(negedge clk);
    check("ld_mrd", out_MemReadData, 32'hDEADBEEF);
    check("ld_rw", out_RegWrite, 1);
    check("ld_req_drop", bus.bus_req, 0);

    // Store at 0x204, ack in the first BUSY cycle
    cyc(); set_op(0, 0, 1, 2'd0, 32'h204, 5'd0, 32'h12345678, 32'h44);
    @(negedge clk); check("st_stall_c0", mem_stall, 1);
    cyc(); bus.bus_ack = 1'b1; bus.bus_rdata = 32'h55555555;
    @(negedge clk);
    check("st_we", bus.bus_we, 1);
    check("st_wdata", bus.bus_wdata, 32'h12345678);
    check("st_stall_ack", mem_stall, 0);
    cyc(); bus.bus_ack = 1'b0; clear_op();
    @(negedge clk); check("st_mrd", out_MemReadData, 0);

    // Back-to-back: load then a read+write op (treated as write)
    cyc(); set_op(1, 1, 0, 2'd1, 32'h10, 5'd3, 32'h0, 32'h50);
    cyc(); bus.bus_ack = 1'b1; bus.bus_rdata = 32'hA5A5A5A5;
    cyc(); bus.bus_ack = 1'b0; set_op(1, 1, 1, 2'd1, 32'h20, 5'd4, 32'h77, 32'h54);
    @(negedge clk);
    check("b2b_gap_req", bus.bus_req, 0);
    check("b2b_stall", mem_stall, 1);
    check("b2b_first_mrd", out_MemReadData, 32'hA5A5A5A5);
    cyc(); bus.bus_ack = 1'b1; bus.bus_rdata = 32'hFFFFFFFF;
    @(negedge clk); check("rw_we", bus.bus_we, 1);
    cyc(); bus.bus_ack = 1'b0; clear_op();
    @(negedge clk); check("rw_mrd", out_MemReadData, 0);

    // Timeout with TIMEOUT_CYCLES=4
    cyc(); set_op(1, 1, 0, 2'd1, 32'h300, 5'd9, 32'h0, 32'h60);
    n_req = 0;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      if (i == 5) clear_op();
      @(negedge clk);
      if (bus.bus_req) n_req++;
      if (i == 4) check("to_stall_last", mem_stall, 0);
      if (i == 5) begin
        check("to_buserr", out_BusErr, 1);
        check("to_rw", out_RegWrite, 0);
        check("to_stall_after", mem_stall, 0);
      end
    end
    check("to_req_cycles", n_req, TO);

    // Reset during the second BUSY cycle; later ack must be ignored
    cyc(); set_op(1, 1, 0, 2'd1, 32'h400, 5'd11, 32'h0, 32'h70);
    cyc();
    cyc(); rst = 1'b1;
    @(negedge clk); check("rst_req_before", bus.bus_req, 1);
    cyc(); rst = 1'b0; clear_op(); bus.bus_ack = 1'b1; bus.bus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    check("rst_req_after", bus.bus_req, 0);
    check("rst_out_rw", out_RegWrite, 0);
    check("rst_out_pc", out_PC, 0);
    cyc(); bus.bus_ack = 1'b0;
    @(negedge clk);
    check("rst_ack_ignored", out_MemReadData, 0);
    check("rst_idle_stall", mem_stall, 0);

    // Misaligned load at 0x102
    cyc(); set_op(1, 1, 0, 2'd1, 32'h102, 5'd12, 32'h0, 32'h80);
    @(negedge clk);
    check("mis_stall", mem_stall, ALIGN_CHK ? 0 : 1);
    cyc();
    if (ALIGN_CHK) begin
      clear_op();
      @(negedge clk);
      check("mis_req", bus.bus_req, 0);
      check("mis_fault", out_AlignFault, 1);
      check("mis_rw", out_RegWrite, 0);
    end else begin
      bus.bus_ack = 1'b1; bus.bus_rdata = 32'h0BADF00D;
      @(negedge clk);
      check("mis_addr", bus.bus_addr, 32'h100);
      check("mis_req", bus.bus_req, 1);
      cyc(); bus.bus_ack = 1'b0; clear_op();
      @(negedge clk);
      check("mis_rw", out_RegWrite, 1);
      check("mis_mrd", out_MemReadData, 32'h0BADF00D);
    end

    cyc(); cyc();
    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage responder of the pipeline. It consumes the EX/MEM pipeline register outputs and runs loads and stores over a req/ack data bus. While a bus transaction is outstanding it stalls the upstream pipeline. It drives registered MEM/WB fields, inserting bubbles during stalls and reporting bus timeouts (and, optionally, misaligned accesses).

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: BUSY cycles without bus_ack before the access is aborted; legal range 1..65535.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- in_RegWrite  input  1  from EX/MEM.
- in_MemRead  input  1  from EX/MEM; load.
- in_MemWrite  input  1  from EX/MEM; store.
- in_MemtoReg  input  2  from EX/MEM; passed through.
- in_ALUOut  input  32  from EX/MEM; effective address or ALU result.
- in_RegWriteAddr  input  5  from EX/MEM.
- in_RFReadData2  input  32  from EX/MEM; store data.
- in_PC  input  32  from EX/MEM.
- mem_stall  output  1  combinational; upstream (PC, IF/ID, ID/EX, EX/MEM) holds while 1.
- bus_req  output  1  registered; transaction request.
- bus_we  output  1  registered; 1 = write.
- bus_addr  output  32  registered; {in_ALUOut[31:2], 2'b00}.
- bus_wdata  output  32  registered store data.
- bus_rdata  input  32  valid when bus_ack = 1.
- bus_ack  input  1  one-cycle completion strobe.
- out_RegWrite, out_MemtoReg[1:0], out_ALUOut[32], out_RegWriteAddr[5], out_PC[32]  output  registered MEM/WB fields.
- out_MemReadData  output  32  registered load data.
- out_BusErr  output  1  registered; access aborted by timeout.
- out_AlignFault  output  1  registered; misaligned access (see Configuration).

## Operation
- States are IDLE and BUSY. A mem op is in_MemRead | in_MemWrite.
- IDLE, no mem op: mem_stall = 0.
  - Each posedge copies the in_* fields to the out_* fields.
  - out_MemReadData, out_BusErr and out_AlignFault are set to 0.
- IDLE, mem op: mem_stall = 1.
  - At the edge: go to BUSY, bus_req ← 1, bus_we ← in_MemWrite, latch bus_addr and bus_wdata, clear the timeout counter.
  - The MEM/WB outputs get a bubble: out_RegWrite ← 0, out_BusErr ← 0, out_AlignFault ← 0.
- If in_MemRead and in_MemWrite are both 1, the access is a write and out_MemReadData ← 0.
- BUSY: mem_stall = !bus_ack && counter != TIMEOUT_CYCLES-1.
  - bus_req, bus_we, bus_addr and bus_wdata stay stable until the access ends.
- BUSY, bus_ack = 1: at the edge, bus_req ← 0 and the state returns to IDLE.
  - The out_* fields are loaded from the in_* fields; these are still valid because EX/MEM was held.
  - For a read, out_MemReadData ← bus_rdata; for a write it is 0.
- BUSY, no ack and counter = TIMEOUT_CYCLES-1: at the edge the access is aborted.
  - bus_req ← 0, state returns to IDLE.
  - out_BusErr ← 1, out_RegWrite ← 0; the other out_* fields are loaded from in_*.
- BUSY, no ack, below the limit: the counter increments; bubble as above.
- bus_ack in IDLE is ignored.
- An ack and the timeout in the same cycle resolve as ack.

## Timing
- Reset: state IDLE, counter 0, every registered output 0.
- rst mid-BUSY drops bus_req at that edge; an ack arriving afterwards is ignored.
- Non-mem op: 1-cycle latency, no stall.
- Mem op presented in cycle 0: bus_req is high from cycle 1.
  - An ack in cycle k ≥ 1 releases mem_stall in cycle k; MEM/WB is updated at edge k+1.
  - Minimum is 2 cycles; total stall is k cycles.
- Back-to-back mem ops: after returning to IDLE, the next op is in EX/MEM.
  - Its stall asserts in the following cycle; bus_req is low for at least 1 cycle between accesses.
- Timeout: bus_req is high for exactly TIMEOUT_CYCLES cycles.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - A mem op with in_ALUOut[1:0] != 0 in IDLE does not stall and issues no bus request.
  - At the edge the out_* fields are loaded, out_RegWrite ← 0, out_AlignFault ← 1.
- MEM_ALIGN_CHECK_EN undefined:
  - out_AlignFault is tied to 0.
  - The low two address bits are dropped and the access proceeds normally.

## Test plan
- ALU op in_RegWrite=1, ALUOut=0x0000_0010, RegWriteAddr=5, no mem op -> next cycle out_RegWrite=1, out_ALUOut=0x10, out_RegWriteAddr=5, mem_stall never 1.
- Load at addr 0x100, ack 3 cycles after bus_req, bus_rdata=0xDEAD_BEEF -> mem_stall high 3 cycles, bus_addr=0x100, bus_we=0, then out_MemReadData=0xDEADBEEF, out_RegWrite=1; bubbles with out_RegWrite=0 meanwhile.
- Store at addr 0x204, RFReadData2=0x1234_5678, ack in the first BUSY cycle -> bus_we=1, bus_wdata=0x12345678, stall 1 cycle, out_MemReadData=0.
- Parameter override TIMEOUT_CYCLES=4, load with no ack -> bus_req high exactly 4 cycles, then out_BusErr=1, out_RegWrite=0, mem_stall low.
- rst pulsed in the 2nd BUSY cycle, ack the next cycle -> bus_req=0 after the reset edge, all outputs 0, ack ignored, state IDLE.
- MEM_ALIGN_CHECK_EN defined, load at 0x102 -> no bus_req, no stall, out_AlignFault=1, out_RegWrite=0; with the macro undefined -> bus_addr=0x100 and a normal access.
